// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped I-cache controller (64 sets x 32-byte lines).
// Holds tag/valid state, answers fetches on hit and refills a missing line
// from physical memory as four 64-bit beats written through byte enables.
// Optional feature macro: ICACHE_PERF_EN (hit/miss counters).
module icache_fill_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic [31:0]  mem_address,
   output logic [31:0]  mem_rdata,
   output logic         mem_resp,
   input  logic         invalidate,
   output logic         pmem_read,
   output logic [31:0]  pmem_address,
   input  logic [63:0]  pmem_rdata,
   input  logic         pmem_valid,
   output logic [31:0]  da_write_en,
   output logic [5:0]   da_rindex,
   output logic [5:0]   da_windex,
   output logic [255:0] da_datain,
   input  logic [255:0] da_dataout,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP} state_t;

   state_t       r_state;
   logic [20:0]  r_tag [64];
   logic [63:0]  r_valid;
   logic [1:0]   r_beat;
   logic [31:2]  r_req_addr;
   logic         r_inv_pend;

   logic [5:0]   w_idx;
   logic [20:0]  w_req_tag;
   logic         w_hit;
   logic         w_lookup;
   logic         w_beat_we;
   logic         w_last_beat;
   logic         w_unused;

   assign w_idx       = r_req_addr[10:5];
   assign w_req_tag   = r_req_addr[31:11];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);
   assign w_lookup    = (r_state == S_LOOKUP);
   assign w_beat_we   = (r_state == S_FILL) && pmem_valid;
   assign w_last_beat = w_beat_we && (r_beat == 2'd3);
   assign w_unused    = &{1'b0, mem_address[1:0]};

   // Control FSM: request capture, lookup, beat sequencing and valid bookkeeping.
   // An invalidate seen during FILL is deferred to the RESP edge so it also
   // clears the line whose valid bit is set by the final beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_beat     <= '0;
         r_inv_pend <= 1'b0;
         r_req_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (invalidate) r_valid <= '0;
               if (mem_read) begin
                  r_req_addr <= mem_address[31:2];
                  r_state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (invalidate) r_valid <= '0;
               if (w_hit) begin
                  r_state <= S_IDLE;
               end else begin
                  r_beat  <= '0;
                  r_state <= S_FILL;
               end
            end
            S_FILL: begin
               if (invalidate) r_inv_pend <= 1'b1;
               if (pmem_valid) begin
                  r_beat <= r_beat + 2'd1;
                  if (r_beat == 2'd3) begin
                     r_valid[w_idx] <= 1'b1;
                     r_state        <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (invalidate || r_inv_pend) r_valid <= '0;
               r_inv_pend <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag store: written on the final fill beat, meaningless while invalid.
   always_ff @(posedge clk) begin
      if (!rst && w_last_beat) r_tag[w_idx] <= w_req_tag;
   end

   assign mem_resp     = (w_lookup && w_hit) || (r_state == S_RESP);
   assign mem_rdata    = mem_resp ? da_dataout[{r_req_addr[4:2], 5'b0} +: 32] : '0;
   assign pmem_read    = (r_state == S_FILL);
   assign pmem_address = {r_req_addr[31:5], 5'b0};
   assign da_rindex    = w_idx;
   assign da_windex    = w_idx;
   assign da_datain    = {4{pmem_rdata}};
   assign da_write_en  = w_beat_we ? (32'h0000_00FF << {r_beat, 3'b000}) : '0;

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   // Saturating lookup outcome counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_lookup) begin
         if (w_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (!w_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: models the external data array, issues directed
// fetches and queues expected responses; a negedge monitor pops and compares.
module tb_icache_fill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic [31:0]  mem_address;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic         invalidate;
   logic         pmem_read;
   logic [31:0]  pmem_address;
   logic [63:0]  pmem_rdata;
   logic         pmem_valid;
   logic [31:0]  da_write_en;
   logic [5:0]   da_rindex;
   logic [5:0]   da_windex;
   logic [255:0] da_datain;
   logic [255:0] da_dataout;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   icache_fill_ctrl dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .invalidate(invalidate),
      .pmem_read(pmem_read), .pmem_address(pmem_address), .pmem_rdata(pmem_rdata),
      .pmem_valid(pmem_valid), .da_write_en(da_write_en), .da_rindex(da_rindex),
      .da_windex(da_windex), .da_datain(da_datain), .da_dataout(da_dataout),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q_rdata[$];
   logic [37:0] q_we[$];
   logic [31:0] q_paddr[$];

   logic [31:0] we_tab [4] = '{32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'hFF00_0000};

   // External data array: byte-enabled write at the edge, bypassed read.
   logic [255:0] arr [64];
   initial for (int i = 0; i < 64; i++) arr[i] = '0;

   always @(posedge clk) begin
      for (int b = 0; b < 32; b++)
         if (da_write_en[b]) arr[da_windex][8*b +: 8] <= da_datain[8*b +: 8];
   end

   always_comb begin
      da_dataout = arr[da_rindex];
      if (da_windex == da_rindex)
         for (int b = 0; b < 32; b++)
            if (da_write_en[b]) da_dataout[8*b +: 8] = da_datain[8*b +: 8];
   end

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: pops an expectation whenever the DUT presents a response,
   // a write beat or the start of a fill request.
   logic prev_pread = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_resp) begin
            if (q_rdata.size() == 0) check("unexpected_resp", 64'(mem_rdata), 64'hDEAD);
            else check("mem_rdata", 64'(mem_rdata), 64'(q_rdata.pop_front()));
         end else begin
            check("rdata_idle_zero", 64'(mem_rdata), 64'h0);
         end
         if (da_write_en != '0) begin
            if (q_we.size() == 0) check("unexpected_write", 64'(da_write_en), 64'h0);
            else check("write_idx_en", 64'({da_windex, da_write_en}), 64'(q_we.pop_front()));
         end
         if (pmem_read && !prev_pread) begin
            if (q_paddr.size() == 0) check("unexpected_pmem_read", 64'(pmem_address), 64'hDEAD);
            else check("pmem_address", 64'(pmem_address), 64'(q_paddr.pop_front()));
         end
      end
      prev_pread = pmem_read;
   end

   // One fetch. inv_beat: beat index carrying an invalidate pulse (-1 none).
   // rst_beat: beat index replaced by a reset pulse (-1 none, no response then).
   task automatic do_read(input logic [31:0] addr, input logic miss,
                          input logic [31:0] exp_pa,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input logic [31:0] exp, input int inv_beat, input int rst_beat);
      logic [63:0] bt [4];
      int   beat;
      int   lat;
      logic saw_pread;
      logic done;
      bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
      beat = 0; lat = 0; saw_pread = 1'b0; done = 1'b0;
      mem_read    = 1'b1;
      mem_address = addr;
      if (rst_beat < 0) q_rdata.push_back(exp);
      if (miss) q_paddr.push_back(exp_pa);
      for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
         @(posedge clk); #1;
         pmem_valid = 1'b0;
         invalidate = 1'b0;
         if (pmem_read && beat < 4) begin
            if (beat == rst_beat) begin
               rst = 1'b1; mem_read = 1'b0;
               @(posedge clk); #1;
               rst = 1'b0;
               @(negedge clk);
               check("rst_midfill_pmem_read", 64'(pmem_read), 64'h0);
               check("rst_midfill_resp", 64'(mem_resp), 64'h0);
               done = 1'b1;
            end else begin
               pmem_valid = 1'b1;
               pmem_rdata = bt[beat];
               q_we.push_back({exp_pa[10:5], we_tab[beat]});
               invalidate = (beat == inv_beat);
               beat++;
            end
         end
         if (!done) begin
            @(negedge clk);
            if (pmem_read) saw_pread = 1'b1;
            if (mem_resp) begin
               done = 1'b1;
               lat  = cyc;
            end
         end
      end
      check("resp_within_bound", 64'(done), 64'h1);
      if (rst_beat < 0) begin
         check("latency", 64'(lat), miss ? 64'd6 : 64'd1);
         check("pmem_read_seen", 64'(saw_pread), 64'(miss));
      end
      @(posedge clk); #1;
      mem_read = 1'b0; pmem_valid = 1'b0; invalidate = 1'b0;
   endtask

   task automatic check_counters(input logic [31:0] eh, input logic [31:0] em);
`ifdef ICACHE_PERF_EN
      check("hit_count", 64'(hit_count), 64'(eh));
      check("miss_count", 64'(miss_count), 64'(em));
`else
      check("hit_count_tied", 64'(hit_count), 64'h0);
      check("miss_count_tied", 64'(miss_count), 64'h0);
      if (eh == em) ;
`endif
   endtask

   task automatic pulse_inv();
      @(posedge clk); #1; invalidate = 1'b1;
      @(posedge clk); #1; invalidate = 1'b0;
   endtask

   localparam logic [63:0] Z = 64'h0;

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_address = '0; invalidate = 1'b0;
      pmem_rdata = '0; pmem_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_mem_resp", 64'(mem_resp), 64'h0);
      check("reset_mem_rdata", 64'(mem_rdata), 64'h0);
      check("reset_pmem_read", 64'(pmem_read), 64'h0);
      check("reset_da_write_en", 64'(da_write_en), 64'h0);
      check_counters(32'd0, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Cold miss, then warm hits on other words of the same line
      do_read(32'h0000_0044, 1'b1, 32'h0000_0040, 64'h1111_1111_1111_1111,
              64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333,
              64'h4444_4444_4444_4444, 32'h1111_1111, -1, -1);
      do_read(32'h0000_0048, 1'b0, 32'h0, Z, Z, Z, Z, 32'h2222_2222, -1, -1);
      check_counters(32'd1, 32'd1);
      do_read(32'h0000_005C, 1'b0, 32'h0, Z, Z, Z, Z, 32'h4444_4444, -1, -1);

      // Stray beat in IDLE must not write or disturb state
      @(posedge clk); #1; pmem_valid = 1'b1; pmem_rdata = '1;
      @(negedge clk);
      check("stray_write_en", 64'(da_write_en), 64'h0);
      check("stray_pmem_read", 64'(pmem_read), 64'h0);
      @(posedge clk); #1; pmem_valid = 1'b0;
      do_read(32'h0000_0048, 1'b0, 32'h0, Z, Z, Z, Z, 32'h2222_2222, -1, -1);

      // Conflict eviction on index 2
      do_read(32'h0000_0840, 1'b1, 32'h0000_0840, 64'h5555_5555_5555_5555,
              64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777,
              64'h8888_8888_8888_8888, 32'h5555_5555, -1, -1);
      do_read(32'h0000_0040, 1'b1, 32'h0000_0040, 64'h9999_9999_9999_9999,
              64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 32'h9999_9999, -1, -1);

      // Invalidate on the second fill beat: data still returned, line lost
      do_read(32'h0000_0064, 1'b1, 32'h0000_0060, 64'h1357_9BDF_2468_ACE0,
              64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
              64'h0123_4567_89AB_CDEF, 32'h1357_9BDF, 1, -1);
      do_read(32'h0000_0064, 1'b1, 32'h0000_0060, 64'h1357_9BDF_2468_ACE0,
              64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
              64'h0123_4567_89AB_CDEF, 32'h1357_9BDF, -1, -1);
      do_read(32'h0000_0040, 1'b1, 32'h0000_0040, 64'h9999_9999_9999_9999,
              64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 32'h9999_9999, -1, -1);

      // Invalidate in IDLE
      do_read(32'h0000_0074, 1'b0, 32'h0, Z, Z, Z, Z, 32'hDEAD_BEEF, -1, -1);
      pulse_inv();
      do_read(32'h0000_0064, 1'b1, 32'h0000_0060, 64'h1357_9BDF_2468_ACE0,
              64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
              64'h0123_4567_89AB_CDEF, 32'h1357_9BDF, -1, -1);
      check_counters(32'd4, 32'd7);

      // Reset after two beats, then a clean full refill
      do_read(32'h0000_1080, 1'b1, 32'h0000_1080, 64'hEEEE_EEEE_EEEE_EEEE,
              64'hEEEE_EEEE_EEEE_EEEE, Z, Z, 32'h0, -1, 2);
      check_counters(32'd0, 32'd0);
      do_read(32'h0000_1080, 1'b1, 32'h0000_1080, 64'hAAAA_BBBB_CCCC_DDDD,
              64'h1212_1212_3434_3434, 64'h5656_5656_7878_7878,
              64'h9A9A_9A9A_BCBC_BCBC, 32'hCCCC_DDDD, -1, -1);
      check_counters(32'd0, 32'd1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rdata_queue_drained", 64'(q_rdata.size()), 64'h0);
      check("write_queue_drained", 64'(q_we.size()), 64'h0);
      check("paddr_queue_drained", 64'(q_paddr.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
